// File: rtl/srl_start_fifo_ctrl_if.sv
// Start-token FIFO handshake bundle: producer write side, consumer read
// side, and the we/addr drive toward the external SRL array.
//   slave  : the controller (drives flags, srl_we, srl_addr, count)
//   master : the surrounding producer/consumer/SRL logic
interface srl_start_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 1
);
    logic                  if_write_ce;
    logic                  if_write;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic                  if_empty_n;
    logic                  srl_we;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [ADDR_WIDTH:0]   num_data_valid;

    modport slave (
        input  if_write_ce,
        input  if_write,
        output if_full_n,
        input  if_read_ce,
        input  if_read,
        output if_empty_n,
        output srl_we,
        output srl_addr,
        output num_data_valid
    );

    modport master (
        output if_write_ce,
        output if_write,
        input  if_full_n,
        output if_read_ce,
        output if_read,
        input  if_empty_n,
        input  srl_we,
        input  srl_addr,
        input  num_data_valid
    );
endinterface

// File: rtl/srl_start_fifo_ctrl.sv
// Pointer/flag controller turning an external SRL array into a
// show-ahead start-token FIFO.
//   clk, reset : clock and synchronous active-high reset
//   bus        : handshake + SRL drive (slave side of the interface)
module srl_start_fifo_ctrl #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1
) (
    input logic                  clk,
    input logic                  reset,
    srl_start_fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] TWO  = (ADDR_WIDTH+1)'(2);

    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_m2;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  full_n;
    logic                  empty_n;
    logic                  push;
    logic                  pop;

    assign push = bus.if_write & bus.if_write_ce & full_n;
    assign pop  = bus.if_read & bus.if_read_ce & empty_n;

    // Index of the entry just behind the head after a pop.
    assign cnt_m2 = cnt - TWO;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            addr    <= '0;
            empty_n <= 1'b0;
            full_n  <= 1'b1;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    // Older entries shift up; the head sits at old cnt.
                    cnt     <= cnt + ONE;
                    addr    <= cnt[ADDR_WIDTH-1:0];
                    empty_n <= 1'b1;
                    if (cnt == LAST)
                        full_n <= 1'b0;
                end
                2'b01: begin
                    cnt    <= cnt - ONE;
                    full_n <= 1'b1;
                    if (cnt > ONE) begin
                        addr <= cnt_m2[ADDR_WIDTH-1:0];
                    end else begin
                        addr    <= '0;
                        empty_n <= 1'b0;
                    end
                end
                // Push+pop: shift moves head up as the read retires it.
                default: ;
            endcase
        end
    end

    assign bus.srl_we         = push;
    assign bus.srl_addr       = addr;
    assign bus.if_full_n      = full_n;
    assign bus.if_empty_n     = empty_n;
    assign bus.num_data_valid = cnt;
endmodule

// File: tb/tb_srl_start_fifo_ctrl.sv
// Bench for srl_start_fifo_ctrl: DEPTH=2 and DEPTH=4 instances share
// stimulus; a selector picks which one is checked.
module tb_srl_start_fifo_ctrl;
    typedef struct {
        bit       rst;
        bit       w;
        bit       wce;
        bit       r;
        bit       rce;
        bit [7:0] d;
        bit       we;
        bit       full_n;
        bit       empty_n;
        bit [2:0] cnt;
        bit [1:0] addr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w = 1'b0, wce = 1'b0;
    logic       r = 1'b0, rce = 1'b0;
    logic [7:0] din = '0;
    bit         sel = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    srl_start_fifo_ctrl_if #(.ADDR_WIDTH(1)) b0 ();
    srl_start_fifo_ctrl_if #(.ADDR_WIDTH(2)) b1 ();

    assign b0.if_write    = w;
    assign b0.if_write_ce = wce;
    assign b0.if_read     = r;
    assign b0.if_read_ce  = rce;
    assign b1.if_write    = w;
    assign b1.if_write_ce = wce;
    assign b1.if_read     = r;
    assign b1.if_read_ce  = rce;

    srl_start_fifo_ctrl #(.DEPTH(2), .ADDR_WIDTH(1)) dut0 (
        .clk(clk), .reset(rst), .bus(b0)
    );
    srl_start_fifo_ctrl #(.DEPTH(4), .ADDR_WIDTH(2)) dut1 (
        .clk(clk), .reset(rst), .bus(b1)
    );

    // External SRL arrays: shift on we, combinational read on addr.
    logic [7:0] srl0 [0:1];
    logic [7:0] srl1 [0:3];

    always @(posedge clk) begin
        if (b0.srl_we) begin
            srl0[0] <= din;
            srl0[1] <= srl0[0];
        end
        if (b1.srl_we) begin
            srl1[0] <= din;
            for (int i = 1; i < 4; i++)
                srl1[i] <= srl1[i-1];
        end
    end

    logic [7:0] dout_m;
    logic       we_m, full_m, empty_m;
    logic [2:0] cnt_m;
    logic [1:0] addr_m;
    int         depth_m;

    always_comb begin
        if (sel) begin
            dout_m  = srl1[b1.srl_addr];
            we_m    = b1.srl_we;
            full_m  = b1.if_full_n;
            empty_m = b1.if_empty_n;
            cnt_m   = b1.num_data_valid;
            addr_m  = b1.srl_addr;
            depth_m = 4;
        end else begin
            dout_m  = srl0[b0.srl_addr];
            we_m    = b0.srl_we;
            full_m  = b0.if_full_n;
            empty_m = b0.if_empty_n;
            cnt_m   = {1'b0, b0.num_data_valid};
            addr_m  = {1'b0, b0.srl_addr};
            depth_m = 2;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input bit rs, input bit ww, input bit wc,
        input bit rr, input bit rc, input bit [7:0] dd,
        input bit ew, input bit ef, input bit ee,
        input bit [2:0] ec, input bit [1:0] ea);
        vec_t v;
        v.rst = rs; v.w = ww; v.wce = wc;
        v.r = rr; v.rce = rc; v.d = dd;
        v.we = ew; v.full_n = ef; v.empty_n = ee;
        v.cnt = ec; v.addr = ea;
        return v;
    endfunction

    task automatic step(input vec_t v);
        logic [7:0] e;
        bit         do_pop;
        @(negedge clk);
        rst = v.rst; w = v.w; wce = v.wce;
        r = v.r; rce = v.rce; din = v.d;
        #1;
        chk("srl_we", int'(we_m), int'(v.we));
        do_pop = v.r && v.rce && (model_cnt > 0) && !v.rst;
        if (do_pop) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                chk("dout", int'(dout_m), int'(e));
            end
        end
        if (v.rst)
            q.delete();
        else if (v.we)
            q.push_back(v.d);
        @(posedge clk);
        #1;
        chk("full_n", int'(full_m), int'(v.full_n));
        chk("empty_n", int'(empty_m), int'(v.empty_n));
        chk("count", int'(cnt_m), int'(v.cnt));
        chk("srl_addr", int'(addr_m), int'(v.addr));
        chk("inv_empty", int'(empty_m), int'(cnt_m != 0));
        chk("inv_full", int'(full_m), int'(int'(cnt_m) != depth_m));
        chk("inv_range", int'(int'(cnt_m) <= depth_m), 1);
        model_cnt = v.cnt;
    endtask

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        // rst w wce r rce d | we full empty cnt addr  (DEPTH=2)
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,0,0,0,0,8'h00, 0,1,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,8'hA1, 1,1,1,1,0));
        tbl.push_back(mk(0,1,1,0,0,8'hB2, 1,0,1,2,1));
        tbl.push_back(mk(0,1,1,0,0,8'hC3, 0,0,1,2,1));
        tbl.push_back(mk(0,0,0,1,1,8'h00, 0,1,1,1,0));
        tbl.push_back(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,8'hA4, 1,1,1,1,0));
        tbl.push_back(mk(0,1,1,1,1,8'hC5, 1,1,1,1,0));
        tbl.push_back(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,1,0,0,0,8'hEE, 0,1,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,8'hD6, 1,1,1,1,0));
        tbl.push_back(mk(0,0,0,1,0,8'h00, 0,1,1,1,0));
        tbl.push_back(mk(0,0,1,1,0,8'h00, 0,1,1,1,0));
        tbl.push_back(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,8'hE7, 1,1,1,1,0));
        tbl.push_back(mk(0,1,1,0,0,8'hF8, 1,0,1,2,1));
        tbl.push_back(mk(0,1,1,1,1,8'h19, 0,1,1,1,0));
        tbl.push_back(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,8'h2A, 1,1,1,1,0));
        tbl.push_back(mk(1,1,1,0,0,8'h3B, 1,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));

        foreach (tbl[i])
            step(tbl[i]);

        // DEPTH=4: mid-operation reset, then a full FIFO-order pass.
        sel = 1'b1;
        step(mk(1,0,0,0,0,8'h00, 0,1,0,0,0));
        step(mk(1,0,0,0,0,8'h00, 0,1,0,0,0));
        step(mk(0,1,1,0,0,8'h51, 1,1,1,1,0));
        step(mk(0,1,1,0,0,8'h52, 1,1,1,2,1));
        step(mk(0,1,1,0,0,8'h53, 1,1,1,3,2));
        step(mk(1,1,1,0,0,8'h54, 1,1,0,0,0));
        step(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));
        step(mk(0,1,1,0,0,8'h61, 1,1,1,1,0));
        step(mk(0,1,1,0,0,8'h62, 1,1,1,2,1));
        step(mk(0,1,1,0,0,8'h63, 1,1,1,3,2));
        step(mk(0,1,1,0,0,8'h64, 1,0,1,4,3));
        step(mk(0,1,1,0,0,8'h65, 0,0,1,4,3));
        step(mk(0,0,0,1,1,8'h00, 0,1,1,3,2));
        step(mk(0,0,0,1,1,8'h00, 0,1,1,2,1));
        step(mk(0,1,1,1,1,8'h66, 1,1,1,2,1));
        step(mk(0,0,0,1,1,8'h00, 0,1,1,1,0));
        step(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));
        step(mk(0,0,0,1,1,8'h00, 0,1,0,0,0));

        chk("sb_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/srl_start_fifo_ctrl.md
Name: srl_start_fifo_ctrl

Overview:
- Pointer/flag controller that turns an external SRL shift-register array into a show-ahead start-token FIFO.
- The array is clocked storage, write-enable shifts it, and its read mux is combinational on addr.
- Sits between a producer task's start-out and a consumer PE's start-in, e.g. in the linear-layer dataflow region.
- Owns the occupancy count, full/empty handshakes and the SRL we/addr drive; it holds no data itself.

Parameters:
- DEPTH, 2, number of SRL entries; must be >= 2.
- ADDR_WIDTH, 1, SRL address width; must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- if_write_ce  input  1  producer clock-enable; a push requires it high.
- if_write  input  1  producer write request.
- if_full_n  output  1  registered; 1 = space available.
- if_read_ce  input  1  consumer clock-enable; a pop requires it high.
- if_read  input  1  consumer read request/acknowledge.
- if_empty_n  output  1  registered; 1 = head entry valid at SRL dout.
- srl_we  output  1  combinational shift/write enable to the SRL array.
- srl_addr  output  ADDR_WIDTH  registered read address of the oldest entry.
- num_data_valid  output  ADDR_WIDTH+1  registered occupancy count, 0..DEPTH.

Behaviour:
- push = if_write & if_write_ce & if_full_n.
- pop = if_read & if_read_ce & if_empty_n.
- srl_we = push. This is purely combinational, with no added latency.
- Occupancy count cnt (ADDR_WIDTH+1 bits):
  - push only: cnt+1.
  - pop only: cnt-1.
  - push & pop, or neither: cnt holds.
- srl_addr is a register:
  - push only: set to cnt (the new head index, since older entries shifted up).
  - pop only with cnt>1: set to cnt-2.
  - pop only with cnt==1: set to 0.
  - otherwise: holds.
  - Invariant: srl_addr == cnt-1 whenever cnt>0.
- if_empty_n:
  - push only: 1.
  - pop only with cnt==1: 0.
  - otherwise: holds.
- if_full_n:
  - push only with cnt==DEPTH-1: 0.
  - pop only: 1.
  - otherwise: holds.
- num_data_valid = cnt.
- Latency: a token pushed at edge t has if_empty_n=1 and is visible on SRL dout in cycle t+1. A pop at edge t frees space, and if_full_n=1 in cycle t+1.
- Show-ahead: the consumer samples dout while if_empty_n=1. Asserting if_read in that cycle consumes the token.
- Write when full: ignored (push gated by if_full_n). No state change, srl_we=0.
- Read when empty: ignored. No state change.
- Simultaneous push & pop at 0<cnt<DEPTH: SRL shifts, and the head index is unchanged because the head moves up one slot while the read retires it. cnt, srl_addr and the flags all hold.
- Simultaneous at cnt==DEPTH: only the pop is legal, so it is handled as pop only. At cnt==0: only the push is legal, so it is handled as push only.
- Clock-enable low on either side masks that side completely.
- Reset (synchronous; wins over any push/pop in the same cycle):
  - cnt=0, srl_addr=0, if_empty_n=0, if_full_n=1, num_data_valid=0.
  - srl_we follows push during reset, but the state still resets.
  - SRL contents are not cleared; they are unreachable until rewritten.
  - Mid-operation reset discards all queued tokens.
- Invariants to assert in the bench:
  - if_empty_n == (cnt!=0).
  - if_full_n == (cnt!=DEPTH).
  - cnt never exceeds DEPTH and never underflows.

Test Plan:
- Reset check (DEPTH=2): hold reset 3 cycles -> if_full_n=1, if_empty_n=0, num_data_valid=0, srl_addr=0, srl_we=0 while idle.
- Fill to full: write tokens A, B on consecutive cycles with ce=1 -> if_empty_n=1 after A. After B: if_full_n=0, num_data_valid=2, srl_addr=1, dout=A. A third write is dropped: srl_we=0, cnt stays 2.
- Drain in order: from full, assert read 2 cycles -> dout A then B. srl_addr goes 1->0->0, if_full_n=1 after the first pop, if_empty_n=0 after the second. A further read gives no change.
- Simultaneous push/pop: cnt=1 holding A, write C with read in the same cycle -> A consumed. Next cycle cnt=1, srl_addr=0, dout=C, flags unchanged.
- Clock-enable masking: if_write=1 with if_write_ce=0 for 4 cycles -> srl_we=0, cnt=0. Then if_read=1 with if_read_ce=0 at cnt=1 -> no pop.
- Mid-operation reset (DEPTH=4): push 3 tokens, then assert reset concurrently with a write -> next cycle cnt=0, if_empty_n=0, if_full_n=1. A subsequent push/pop sequence of 4 tokens returns them in FIFO order.
